// File: rtl/ws2812b_rx.sv
// WS2812B single-wire NRZ receiver: decodes pulse widths into 24-bit pixels.
// Define WS2812B_RX_FWD_EN to forward the line after the first pixel of a frame.
module ws2812b_rx #(
    parameter int T_THRESH   = 17,
    parameter int T_MIN_HIGH = 4,
    parameter int T_MAX_HIGH = 48,
    parameter int T_RESET    = 200,
    parameter int CNT_W      = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_data,
    output logic       o_valid,
    output logic [7:0] o_red,
    output logic [7:0] o_green,
    output logic [7:0] o_blue,
    output logic       o_err,
    output logic       o_busy,
    output logic       o_dout
);

    localparam logic [CNT_W:0]   W_MIN = (CNT_W+1)'(T_MIN_HIGH);
    localparam logic [CNT_W:0]   W_MAX = (CNT_W+1)'(T_MAX_HIGH);
    localparam logic [CNT_W:0]   W_TH  = (CNT_W+1)'(T_THRESH);
    localparam logic [CNT_W-1:0] L_END = CNT_W'(T_RESET - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_FWD
    } state_t;

    state_t             r_state, n_state;
    logic               r_s1, r_s2, r_s3;
    logic [CNT_W-1:0]   r_hcnt, n_hcnt;
    logic [CNT_W-1:0]   r_lcnt, n_lcnt;
    logic [4:0]         r_idx, n_idx;
    logic [23:0]        r_color, n_color;
    logic               n_valid, n_err;

    logic               w_rise, w_fall;
    logic [CNT_W:0]     w_width;
    logic [CNT_W-1:0]   w_hinc, w_linc;

    assign w_rise  = r_s2 & ~r_s3;
    assign w_fall  = ~r_s2 & r_s3;
    // hcnt is cleared on the rising cycle, so the width includes that cycle
    assign w_width = {1'b0, r_hcnt} + (CNT_W+1)'(1);
    assign w_hinc  = (&r_hcnt) ? r_hcnt : r_hcnt + CNT_W'(1);
    assign w_linc  = (&r_lcnt) ? r_lcnt : r_lcnt + CNT_W'(1);
    assign o_busy  = (r_idx != 5'd0) | r_s2;

    always_comb begin
        n_state = r_state;
        n_hcnt  = r_hcnt;
        n_lcnt  = r_lcnt;
        n_idx   = r_idx;
        n_color = r_color;
        n_valid = 1'b0;
        n_err   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    n_state = S_HIGH;
                    n_hcnt  = '0;
                end
            end
            S_HIGH: begin
                if (w_fall) begin
                    n_state = S_LOW;
                    n_lcnt  = '0;
                    if (w_width > W_MAX) begin
                        n_err = 1'b1;
                    end else if (w_width >= W_MIN) begin
                        n_color[r_idx] = (w_width >= W_TH);
                        if (r_idx == 5'd23) begin
                            n_idx   = 5'd0;
                            n_valid = 1'b1;
`ifdef WS2812B_RX_FWD_EN
                            n_state = S_FWD;
`endif
                        end else begin
                            n_idx = r_idx + 5'd1;
                        end
                    end
                end else begin
                    n_hcnt = w_hinc;
                end
            end
            S_LOW: begin
                if (w_rise) begin
                    n_state = S_HIGH;
                    n_hcnt  = '0;
                end else if (r_lcnt >= L_END) begin
                    n_state = S_IDLE;
                    n_err   = (r_idx != 5'd0);
                    n_idx   = 5'd0;
                end else begin
                    n_lcnt = w_linc;
                end
            end
`ifdef WS2812B_RX_FWD_EN
            S_FWD: begin
                if (r_s2) begin
                    n_lcnt = '0;
                end else if (r_lcnt >= L_END) begin
                    n_state = S_IDLE;
                end else begin
                    n_lcnt = w_linc;
                end
            end
`endif
            default: n_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_lcnt  <= '0;
            r_idx   <= 5'd0;
            r_color <= 24'd0;
            o_valid <= 1'b0;
            o_err   <= 1'b0;
            o_red   <= 8'd0;
            o_green <= 8'd0;
            o_blue  <= 8'd0;
        end else begin
            r_s1    <= i_data;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_state <= n_state;
            r_hcnt  <= n_hcnt;
            r_lcnt  <= n_lcnt;
            r_idx   <= n_idx;
            r_color <= n_color;
            o_valid <= n_valid;
            o_err   <= n_err;
            if (n_valid) begin
                o_red   <= n_color[7:0];
                o_green <= n_color[15:8];
                o_blue  <= n_color[23:16];
            end
        end
    end

`ifdef WS2812B_RX_FWD_EN
    logic r_dout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dout <= 1'b0;
        end else begin
            r_dout <= (r_state == S_FWD) ? r_s3 : 1'b0;
        end
    end

    assign o_dout = r_dout;
`else
    assign o_dout = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812b_rx.sv
// Randomized scoreboard bench for ws2812b_rx against a pulse-level model.
`timescale 1ns/1ps
module tb_ws2812b_rx;

    localparam int T_THRESH   = 17;
    localparam int T_MIN_HIGH = 4;
    localparam int T_MAX_HIGH = 48;
    localparam int T_RESET    = 200;
`ifdef WS2812B_RX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_data = 1'b0;
    logic       o_valid, o_err, o_busy, o_dout;
    logic [7:0] o_red, o_green, o_blue;

    ws2812b_rx dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_red   (o_red),
        .o_green (o_green),
        .o_blue  (o_blue),
        .o_err   (o_err),
        .o_busy  (o_busy),
        .o_dout  (o_dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [23:0] col;
        longint      stamp;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    longint      cyc = 0;
    logic [3:0]  hist = 4'd0;
    bit          fwd_win = 1'b0;

    int          m_idx = 0;
    logic [23:0] m_col = 24'd0;
    bit          m_fwd = 1'b0;
    int          lowrun = T_RESET;

    always @(posedge clk) begin
        cyc++;
        hist = {hist[2:0], i_data};
    end

    task automatic push(input bit e, input logic [23:0] c, input longint s);
        exp_t x;
        x.is_err = e;
        x.col    = c;
        x.stamp  = s;
        q.push_back(x);
    endtask

    // Reference: classify each whole high pulse by width, low runs end frames
    task automatic model_high(input int n, input longint stamp);
        if (m_fwd || n < T_MIN_HIGH) return;
        if (n > T_MAX_HIGH) begin
            push(1'b1, 24'd0, stamp);
            return;
        end
        m_col[m_idx] = (n >= T_THRESH);
        if (m_idx == 23) begin
            push(1'b0, m_col, stamp);
            m_idx = 0;
            m_fwd = FWD;
        end else begin
            m_idx++;
        end
    endtask

    task automatic seg(input bit lvl, input int n);
        longint c0;
        c0 = cyc;
        if (lvl) begin
            lowrun = 0;
            model_high(n, c0 + n + 3);
        end else begin
            if (lowrun < T_RESET && lowrun + n >= T_RESET) begin
                if (m_idx != 0) push(1'b1, 24'd0, -1);
                m_idx = 0;
                m_fwd = 1'b0;
            end
            lowrun += n;
        end
        i_data = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input bit b, input int hi, input int lo);
        seg(1'b1, hi);
        seg(1'b0, lo);
    endtask

    task automatic send_pixel(input logic [23:0] w);
        for (int i = 0; i < 24; i++)
            send_bit(w[i], w[i] ? 24 : 10, w[i] ? 11 : 25);
    endtask

    task automatic send_rand_pixel(input logic [23:0] w);
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 30) == 0) send_bit(1'b0, 2, 8);
            if ($urandom_range(0, 40) == 0) send_bit(1'b0, 60, 9);
            send_bit(w[i],
                     w[i] ? $urandom_range(17, 48) : $urandom_range(4, 16),
                     $urandom_range(6, 40));
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        i_data = 1'b0;
        i_rst  = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_err", 32'(o_err), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_rgb", 32'({o_blue, o_green, o_red}), 0);
        chk("rst_dout", 32'(o_dout), 0);
        i_rst  = 1'b0;
        m_idx  = 0;
        m_fwd  = 1'b0;
        lowrun = T_RESET;
        repeat (3) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!i_rst && (o_valid || o_err)) begin
            chk("excl", 32'(o_valid & o_err), 0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected valid=%0b err=%0b cyc=%0d",
                         o_valid, o_err, cyc);
            end else begin
                e = q.pop_front();
                chk("kind_err", 32'(o_err), 32'(e.is_err));
                if (!e.is_err)
                    chk("pixel", 32'({o_blue, o_green, o_red}), 32'(e.col));
                if (e.stamp >= 0)
                    chk("timing", 32'(cyc), 32'(e.stamp));
                if (!FWD) chk("dout_off", 32'(o_dout), 0);
            end
        end
        if (fwd_win) chk("dout_fwd", 32'(o_dout), 32'(hist[3]));
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] w;
        @(negedge clk);
        do_reset();

        send_pixel(24'h0FC35A);
        seg(1'b0, 250);
        chk("idle_busy", 32'(o_busy), 0);

        send_pixel(24'h010203);
        fwd_win = FWD;
        send_pixel(24'hFFFFFF);
        seg(1'b0, 100);
        fwd_win = 1'b0;
        seg(1'b0, 150);

        w = 24'hA5_3C_E1;
        for (int i = 0; i < 24; i++) begin
            if (i == 5) begin
                seg(1'b1, 24);
                seg(1'b0, 8);
                seg(1'b1, 2);
                seg(1'b0, 3);
            end else begin
                send_bit(w[i], w[i] ? 24 : 10, w[i] ? 11 : 25);
            end
        end
        seg(1'b0, 250);

        w = 24'h5A_5A_5A;
        for (int i = 0; i < 24; i++)
            send_bit(w[i], (i == 8) ? 60 : (w[i] ? 24 : 10), 11);
        seg(1'b0, 250);

        for (int i = 0; i < 10; i++) send_bit(i[0], i[0] ? 24 : 10, 11);
        seg(1'b0, 250);
        chk("partial_busy", 32'(o_busy), 0);
        send_pixel(24'h7E_81_3F);
        seg(1'b0, 250);

        for (int i = 0; i < 12; i++) send_bit(1'b1, 24, 11);
        do_reset();
        send_pixel(24'h123456);
        seg(1'b0, 250);

        seg(1'b1, 3);
        seg(1'b0, 10);
        seg(1'b1, 49);
        seg(1'b0, 10);
        w = 24'hC6_39_96;
        for (int i = 0; i < 24; i++)
            send_bit(w[i], w[i] ? (i[0] ? 17 : 48) : (i[0] ? 4 : 16), 8);
        seg(1'b0, 250);

        for (int p = 0; p < 14; p++) begin
            send_rand_pixel(24'($urandom));
            if ($urandom_range(0, 2) == 0) seg(1'b0, 250);
        end
        seg(1'b0, 250);

        repeat (20) @(negedge clk);
        chk("leftover", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
